mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Executes the HI/LO-class instructions that the ALU does not handle, using an iterative shift-add multiplier and a restoring divider.
- Owns the architectural HI/LO registers.
- The pipeline control issues a request through a start/busy/done handshake and stalls on o_busy.

Parameters:
- HILO_RESET, 32'h0, reset value of both HI and LO.
- DIV0_LO, 32'hFFFFFFFF, LO value written on divide-by-zero.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  request strobe; sampled only in IDLE.
- i_op  input  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; 10-15 reserved.
- i_opr1  input  32  rs value: multiplicand, dividend, or MTHI/MTLO source.
- i_opr2  input  32  rt value: multiplier or divisor.
- i_cancel  input  1  pipeline flush; aborts the current operation.
- o_busy  output  1  high while an operation is in flight.
- o_done  output  1  one-cycle pulse when HI/LO have just been updated.
- o_div_by_zero  output  1  qualifies o_done; high when the completing DIV/DIVU had a zero divisor.
- o_hi  output  32  HI register.
- o_lo  output  32  LO register.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE.
  - o_hi=o_lo=HILO_RESET.
  - o_busy=0, o_done=0, o_div_by_zero=0.
  - Reset mid-operation discards all work.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - i_start=1 with i_op 0-7: latch operands and op, counter=0, go to CALC. o_busy rises the cycle after acceptance.
  - i_start=1 with MTHI/MTLO: write i_opr1 to HI or LO on the accepting edge; o_done pulses the next cycle; stay in IDLE; o_busy stays 0.
  - Reserved op: ignored, no state change.
  - i_cancel=1 in the same cycle as i_start: cancel wins and nothing is accepted.
- CALC: 32 iterations, one bit per cycle; counter 0..31; go to FIX when counter=31.
  - Signed ops first convert the operands to magnitudes at latch time.
  - Multiply: 64-bit shift-add on the magnitudes.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
- FIX (1 cycle): sign correction, then writeback to HI/LO.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - MADD/MSUB(U): {HI,LO} += / -= the product, modulo 2^64, no overflow flag.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - Result: LO=quotient, HI=remainder.
  - Then go to DONE.
- DONE (1 cycle): o_done=1, o_busy=0, return to IDLE. A new i_start is accepted from the following cycle.
- Latency: acceptance edge, then 32 CALC cycles and 1 FIX cycle. HI/LO update on the 34th edge after acceptance; o_done is visible during the next cycle.
- o_busy=1 throughout CALC and FIX. i_start while busy is ignored; the requester must hold/replay it.
- Divide-by-zero (divisor=0): CALC still runs. FIX writes HI=dividend (raw i_opr1) and LO=DIV0_LO; o_div_by_zero=1 with o_done.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no flag.
- i_cancel in CALC or FIX: next edge goes to IDLE, HI/LO unchanged, no o_done; o_busy falls that edge.
- i_cancel in DONE: no effect, since the write has already committed.
- o_hi/o_lo are registered and change only on FIX or MTHI/MTLO edges. Reads during busy return the pre-operation values.

Test Plan:
- Reset with HILO_RESET=0: o_hi=o_lo=0, o_busy=0. Then MULT 0xFFFFFFFD x 5 -> after 34 edges, o_hi=0xFFFFFFFF, o_lo=0xFFFFFFF1, one-cycle o_done.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> o_hi=0xFFFFFFFE, o_lo=0x00000001. DIVU 100/7 -> o_lo=14, o_hi=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> o_lo=0x80000000, o_hi=0, o_div_by_zero=0.
- DIVU 0x1234 / 0 -> o_hi=0x1234, o_lo=0xFFFFFFFF, o_div_by_zero=1 coincident with o_done.
- MTHI 0, MTLO 0x10, then MADD 3x4 -> o_lo=0x1C, o_hi=0. MSUB 0x1D x 1 -> o_hi=o_lo=0xFFFFFFFF.
- Start DIVU, then raise i_start with new operands at CALC cycle 5 (ignored) and i_cancel at cycle 10 -> o_busy falls next edge, HI/LO unchanged, no o_done. Async reset asserted mid-CALC -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit for the EX stage.
// Owns the architectural HI/LO registers. A request is accepted in IDLE,
// runs 32 one-bit iterations in CALC (shift-add multiply or restoring
// divide on operand magnitudes), applies sign correction and accumulation
// in FIX, and pulses o_done from DONE. MTHI/MTLO complete directly in IDLE.
module mul_div_unit #(
   parameter logic [31:0] HILO_RESET = 32'h0,
   parameter logic [31:0] DIV0_LO    = 32'hFFFF_FFFF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [3:0]  i_op,
   input  logic [31:0] i_opr1,
   input  logic [31:0] i_opr2,
   input  logic        i_cancel,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_div_by_zero,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   // Operation encodings on i_op.
   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MADD  = 4'd4;
   localparam logic [3:0] OP_MADDU = 4'd5;
   localparam logic [3:0] OP_MSUB  = 4'd6;
   localparam logic [3:0] OP_MSUBU = 4'd7;
   localparam logic [3:0] OP_MTHI  = 4'd8;
   localparam logic [3:0] OP_MTLO  = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;

   // Latched request and iteration state.
   logic [3:0]  op_q;
   logic [4:0]  cnt_q;
   logic [31:0] opnd_q;     // multiplicand magnitude, or divisor magnitude
   logic [63:0] work_q;     // mul: {partial product, multiplier}; div: {remainder, quotient}
   logic [31:0] raw_a_q;    // raw dividend, written to HI on divide-by-zero
   logic        neg_res_q;  // negate product / quotient in FIX
   logic        neg_rem_q;  // negate remainder in FIX
   logic        dz_q;       // divisor was zero
   logic        mt_done_q;  // MTHI/MTLO written last edge
   logic [31:0] hi_q, lo_q;

   // Control strobes from the next-state logic.
   logic        start_calc;
   logic        mt_write;
   logic        fix_commit;

   // Request decode (live inputs, used at acceptance).
   logic        req_div, req_signed, req_calc, req_mt;
   logic [31:0] mag1, mag2;

   // Latched-op decode (used in CALC and FIX).
   logic        cur_div, cur_acc, cur_sub;

   // Datapath intermediates.
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_rem;
   logic [63:0] div_next;
   logic [63:0] prod_signed;
   logic [63:0] mul_result;
   logic [31:0] quo_fixed, rem_fixed;
   logic [31:0] fix_hi, fix_lo;

   // Decode the incoming request and form operand magnitudes.
   always_comb begin
      req_div    = (i_op == OP_DIV) || (i_op == OP_DIVU);
      req_signed = (i_op == OP_MULT) || (i_op == OP_DIV) ||
                   (i_op == OP_MADD) || (i_op == OP_MSUB);
      req_calc   = (i_op <= OP_MSUBU);
      req_mt     = (i_op == OP_MTHI) || (i_op == OP_MTLO);
      mag1       = (req_signed && i_opr1[31]) ? (~i_opr1 + 32'd1) : i_opr1;
      mag2       = (req_signed && i_opr2[31]) ? (~i_opr2 + 32'd1) : i_opr2;
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // FSM next-state, handshake outputs and datapath strobes.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would infer a latch.
      state_d       = state_q;
      start_calc    = 1'b0;
      mt_write      = 1'b0;
      fix_commit    = 1'b0;
      o_busy        = 1'b0;
      o_done        = mt_done_q;
      o_div_by_zero = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start && !i_cancel) begin
               if (req_calc) begin
                  start_calc = 1'b1;
                  state_d    = S_CALC;
               end else if (req_mt) begin
                  mt_write = 1'b1;
               end
            end
         end
         S_CALC: begin
            o_busy = 1'b1;
            if (i_cancel)              state_d = S_IDLE;
            else if (cnt_q == 5'd31)   state_d = S_FIX;
         end
         S_FIX: begin
            o_busy = 1'b1;
            if (i_cancel) begin
               state_d = S_IDLE;
            end else begin
               fix_commit = 1'b1;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            o_done        = 1'b1;
            o_div_by_zero = dz_q;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // One iteration step of each algorithm, plus FIX-stage correction.
   always_comb begin
      cur_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
      cur_acc = (op_q >= OP_MADD) && (op_q <= OP_MSUBU);
      cur_sub = (op_q == OP_MSUB) || (op_q == OP_MSUBU);

      // Shift-add: add multiplicand into the upper half when the current
      // multiplier bit is set, then shift the 65-bit result right by one.
      mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
      mul_next = {mul_sum, work_q[31:1]};

      // Restoring divide: shift the next dividend bit into the remainder
      // and subtract the divisor when it fits. The partial remainder stays
      // below the divisor, so a 32-bit subtraction is exact when it fits.
      div_shift = {work_q[63:32], work_q[31]};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      div_rem   = div_ge ? (div_shift[31:0] - opnd_q) : div_shift[31:0];
      div_next  = {div_rem, work_q[30:0], div_ge};

      prod_signed = neg_res_q ? (~work_q + 64'd1) : work_q;
      if (!cur_acc)     mul_result = prod_signed;
      else if (cur_sub) mul_result = {hi_q, lo_q} - prod_signed;
      else              mul_result = {hi_q, lo_q} + prod_signed;

      quo_fixed = neg_res_q ? (~work_q[31:0] + 32'd1)  : work_q[31:0];
      rem_fixed = neg_rem_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];

      if (!cur_div) begin
         fix_hi = mul_result[63:32];
         fix_lo = mul_result[31:0];
      end else if (dz_q) begin
         fix_hi = raw_a_q;
         fix_lo = DIV0_LO;
      end else begin
         fix_hi = rem_fixed;
         fix_lo = quo_fixed;
      end
   end

   // Operand latch and iteration datapath.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_q      <= OP_MULT;
         cnt_q     <= 5'd0;
         opnd_q    <= 32'd0;
         work_q    <= 64'd0;
         raw_a_q   <= 32'd0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
      end else if (start_calc) begin
         op_q      <= i_op;
         cnt_q     <= 5'd0;
         opnd_q    <= req_div ? mag2 : mag1;
         work_q    <= {32'd0, req_div ? mag1 : mag2};
         raw_a_q   <= i_opr1;
         neg_res_q <= req_signed && (i_opr1[31] ^ i_opr2[31]);
         neg_rem_q <= req_signed && i_opr1[31];
         dz_q      <= req_div && (i_opr2 == 32'd0);
      end else if (state_q == S_CALC) begin
         cnt_q  <= cnt_q + 5'd1;
         work_q <= cur_div ? div_next : mul_next;
      end
   end

   // Architectural HI/LO registers and the MTHI/MTLO completion pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hi_q      <= HILO_RESET;
         lo_q      <= HILO_RESET;
         mt_done_q <= 1'b0;
      end else begin
         mt_done_q <= mt_write;
         if (mt_write) begin
            if (i_op == OP_MTHI) hi_q <= i_opr1;
            else                 lo_q <= i_opr1;
         end else if (fix_commit) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end
      end
   end

   assign o_hi = hi_q;
   assign o_lo = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed cases plus randomized operations,
// compared against an arithmetic reference model of HI/LO.
module tb_mul_div_unit;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_start;
   logic [3:0]  i_op;
   logic [31:0] i_opr1, i_opr2;
   logic        i_cancel;
   logic        o_busy, o_done, o_div_by_zero;
   logic [31:0] o_hi, o_lo;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [31:0] m_hi, m_lo;
   logic        m_dz;

   mul_div_unit dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_op          (i_op),
      .i_opr1        (i_opr1),
      .i_opr2        (i_opr2),
      .i_cancel      (i_cancel),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_div_by_zero (o_div_by_zero),
      .o_hi          (o_hi),
      .o_lo          (o_lo)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: architectural effect of one operation on HI/LO.
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int          sa, sb;
      longint      sp;
      logic [63:0] p, acc;
      sa   = a;
      sb   = b;
      sp   = longint'(sa) * longint'(sb);
      p    = (op == 4'd0 || op == 4'd4 || op == 4'd6) ? 64'(sp) : ({32'd0, a} * {32'd0, b});
      acc  = {m_hi, m_lo};
      m_dz = 1'b0;
      case (op)
         4'd0, 4'd1: {m_hi, m_lo} = p;
         4'd4, 4'd5: {m_hi, m_lo} = acc + p;
         4'd6, 4'd7: {m_hi, m_lo} = acc - p;
         4'd2, 4'd3: begin
            if (b == 32'd0) begin
               m_hi = a; m_lo = 32'hFFFF_FFFF; m_dz = 1'b1;
            end else if (op == 4'd3) begin
               m_lo = a / b; m_hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               m_lo = 32'h8000_0000; m_hi = 32'd0;
            end else begin
               m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
            end
         end
         4'd8: m_hi = a;
         4'd9: m_lo = a;
         default: ;
      endcase
   endtask

   // Issue one request and check its full handshake and result.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] pre_hi, pre_lo;
      int          edges;
      pre_hi = m_hi;
      pre_lo = m_lo;
      model(op, a, b);
      @(negedge i_clk);
      i_start = 1'b1; i_op = op; i_opr1 = a; i_opr2 = b;
      @(negedge i_clk);
      i_start = 1'b0; i_op = 4'($urandom_range(0, 15));
      i_opr1 = $urandom; i_opr2 = $urandom;
      if (op == 4'd8 || op == 4'd9) begin
         check("mt_done", o_done, 1'b1);
         check("mt_busy", o_busy, 1'b0);
         check("mt_hi", o_hi, m_hi);
         check("mt_lo", o_lo, m_lo);
         @(negedge i_clk);
         check("mt_done_pulse", o_done, 1'b0);
      end else if (op <= 4'd7) begin
         check("busy_rise", o_busy, 1'b1);
         check("hi_hold_busy", o_hi, pre_hi);
         check("lo_hold_busy", o_lo, pre_lo);
         edges = 1;
         while (!o_done && edges < 100) begin
            @(negedge i_clk);
            edges++;
         end
         check("edges_to_done", edges, 34);
         check("busy_at_done", o_busy, 1'b0);
         check("div_by_zero", o_div_by_zero, m_dz);
         check("hi", o_hi, m_hi);
         check("lo", o_lo, m_lo);
         @(negedge i_clk);
         check("done_pulse", o_done, 1'b0);
      end else begin
         check("rsv_busy", o_busy, 1'b0);
         check("rsv_done", o_done, 1'b0);
         @(negedge i_clk);
         check("rsv_idle", {o_busy, o_done}, 2'b00);
         check("rsv_hilo", {o_hi, o_lo}, {pre_hi, pre_lo});
      end
   endtask

   initial begin
      int seen;
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      i_rst_n = 1'b0; i_start = 1'b0; i_op = 4'd0;
      i_opr1 = 32'd0; i_opr2 = 32'd0; i_cancel = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0;
      #12;
      check("rst_hi", o_hi, 32'd0);
      check("rst_lo", o_lo, 32'd0);
      check("rst_flags", {o_busy, o_done, o_div_by_zero}, 3'b000);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Directed cases.
      run_op(4'd0, 32'hFFFF_FFFD, 32'd5);
      run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(4'd3, 32'd100, 32'd7);
      run_op(4'd2, 32'hFFFF_FFF9, 32'd2);
      run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(4'd3, 32'h1234, 32'd0);
      run_op(4'd2, 32'd7, 32'hFFFF_FFFE);
      run_op(4'd8, 32'd0, 32'd0);
      run_op(4'd9, 32'h10, 32'd0);
      run_op(4'd4, 32'd3, 32'd4);
      run_op(4'd6, 32'h1D, 32'd1);
      run_op(4'd12, 32'h5555, 32'd3);

      // Randomized operations, biased toward corner operands.
      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 10));
         ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 :
               ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
         run_op(rop, ra, rb);
      end

      // Start while busy is ignored; cancel mid-CALC aborts with no write.
      @(negedge i_clk);
      i_start = 1'b1; i_op = 4'd3; i_opr1 = 32'hFFFF_0000; i_opr2 = 32'd3;
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (5) @(negedge i_clk);
      i_start = 1'b1; i_op = 4'd0; i_opr1 = 32'd9; i_opr2 = 32'd9;
      @(negedge i_clk);
      i_start = 1'b0;
      check("busy_ignores_start", o_busy, 1'b1);
      repeat (4) @(negedge i_clk);
      i_cancel = 1'b1;
      @(negedge i_clk);
      i_cancel = 1'b0;
      check("cancel_busy_fall", o_busy, 1'b0);
      check("cancel_no_done", o_done, 1'b0);
      check("cancel_hilo", {o_hi, o_lo}, {m_hi, m_lo});
      seen = 0;
      repeat (40) begin
         @(negedge i_clk);
         if (o_done || o_busy) seen++;
      end
      check("cancel_quiet", seen, 0);

      // Cancel together with start in IDLE: nothing accepted.
      i_start = 1'b1; i_cancel = 1'b1; i_op = 4'd8; i_opr1 = 32'hDEAD_BEEF;
      @(negedge i_clk);
      i_start = 1'b0; i_cancel = 1'b0;
      check("cancel_start_done", o_done, 1'b0);
      check("cancel_start_hi", o_hi, m_hi);
      check("cancel_start_busy", o_busy, 1'b0);

      // Asynchronous reset in the middle of CALC.
      run_op(4'd8, 32'h55, 32'd0);
      run_op(4'd9, 32'hAA, 32'd0);
      @(negedge i_clk);
      i_start = 1'b1; i_op = 4'd1; i_opr1 = 32'd6; i_opr2 = 32'd7;
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (7) @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      check("arst_hi", o_hi, 32'd0);
      check("arst_lo", o_lo, 32'd0);
      check("arst_flags", {o_busy, o_done, o_div_by_zero}, 3'b000);
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      run_op(4'd5, 32'd3, 32'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
